// File: rtl/data_sram_rw_ctrl.sv
// Arbitrates read/write requests onto the single RW0 port of the data SRAM; read responses via a small FIFO.
// Latency: write commits at the accept edge; read data reaches io_r_resp_* 2 cycles after the accept edge.
// Backpressure: reads are granted only when FIFO space is guaranteed; writes win until the streak limit lets a waiting read in.
module data_sram_rw_ctrl #(
  parameter int ADDR_W        = 10,
  parameter int DATA_W        = 512,
  parameter int RESP_DEPTH    = 2,
  parameter int WR_STREAK_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_r_req_valid,
  output logic              io_r_req_ready,
  input  logic [ADDR_W-1:0] io_r_req_addr,
  input  logic              io_w_req_valid,
  output logic              io_w_req_ready,
  input  logic [ADDR_W-1:0] io_w_req_addr,
  input  logic [DATA_W-1:0] io_w_req_data,
  output logic              io_r_resp_valid,
  input  logic              io_r_resp_ready,
  output logic [DATA_W-1:0] io_r_resp_data,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int STK_W = $clog2(WR_STREAK_MAX + 1);

  localparam logic [CNT_W:0]   DEPTH_V  = (CNT_W+1)'(RESP_DEPTH);
  localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(RESP_DEPTH);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(WR_STREAK_MAX);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RESP_DEPTH - 1);

  // State
  logic              r_s1_valid;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [STK_W-1:0]  r_streak;
  logic [DATA_W-1:0] r_mem [RESP_DEPTH];

  // Combinational decode
  logic             w_pop;
  logic             w_push;
  logic [CNT_W:0]   w_occ;
  logic             w_credit_ok;
  logic             w_rd_elig;
  logic             w_rd_grant;
  logic             w_wr_grant;

  assign w_pop  = io_r_resp_valid && io_r_resp_ready;
  assign w_push = r_s1_valid;

  // Occupancy the FIFO will have after this cycle's pop, counting the read already in the SRAM pipe.
  // A pop implies count >= 1, so this never underflows.
  assign w_occ       = {1'b0, r_count} + {{CNT_W{1'b0}}, r_s1_valid} - {{CNT_W{1'b0}}, w_pop};
  assign w_credit_ok = (w_occ < DEPTH_V);
  assign w_rd_elig   = io_r_req_valid && w_credit_ok;

  // One grant per cycle: forced read at the streak limit, else write priority, else read.
  always_comb begin
    w_rd_grant = 1'b0;
    w_wr_grant = 1'b0;
    if (!reset) begin
      if ((r_streak == STK_MAX) && w_rd_elig) begin
        w_rd_grant = 1'b1;
      end else if (io_w_req_valid) begin
        w_wr_grant = 1'b1;
      end else if (w_rd_elig) begin
        w_rd_grant = 1'b1;
      end
    end
  end

  assign io_r_req_ready = w_rd_grant;
  assign io_w_req_ready = w_wr_grant;

  assign sram_en    = w_rd_grant || w_wr_grant;
  assign sram_wmode = w_wr_grant;
  assign sram_addr  = w_wr_grant ? io_w_req_addr : io_r_req_addr;
  assign sram_wdata = io_w_req_data;

  assign io_r_resp_valid = (r_count != '0);
  assign io_r_resp_data  = r_mem[r_rptr];

  // Count consecutive write grants that held off an eligible read; any cycle without a waiting read resets it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_streak <= '0;
    end else if (w_rd_grant || !w_rd_elig) begin
      r_streak <= '0;
    end else if (w_wr_grant && (r_streak != STK_MAX)) begin
      r_streak <= r_streak + 1'b1;
    end
  end

  // Track the SRAM's one-cycle read latency; a back-to-back read keeps the stage occupied.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_rd_grant;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop advance both pointers and keep the count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + 1'b1;
      end
      if (w_push && !w_pop && (r_count != COUNT_FULL)) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Capture SRAM read data into the FIFO; storage needs no reset since count gates visibility.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wptr] <= sram_rdata;
    end
  end

endmodule

// File: doc/data_sram_rw_ctrl.md
# data_sram_rw_ctrl

Request-side controller that sits directly upstream of the 1024×512 single-port data SRAM macro and drives its RW0 port. It arbitrates independent read and write request channels onto the single port, one access per cycle. Writes win by default, with a streak limit so reads cannot starve. It tracks the macro's one-cycle read latency and returns read data through a small response FIFO with valid/ready backpressure. Reads are issued only when FIFO space is guaranteed, so no response is ever dropped.

## Interface
- ADDR_W, 10, SRAM address width
- DATA_W, 512, SRAM data width
- RESP_DEPTH, 2, response FIFO entries (≥2)
- WR_STREAK_MAX, 4, consecutive write grants allowed while a read is eligible and waiting
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high
- io_r_req_valid / io_r_req_ready  in/out  1  read request handshake
- io_r_req_addr  in  ADDR_W  read address
- io_w_req_valid / io_w_req_ready  in/out  1  write request handshake
- io_w_req_addr  in  ADDR_W  write address
- io_w_req_data  in  DATA_W  write data
- io_r_resp_valid / io_r_resp_ready  out/in  1  read response handshake
- io_r_resp_data  out  DATA_W  read data, in request order
- sram_en, sram_wmode  out  1  to RW0_en, RW0_wmode
- sram_addr  out  ADDR_W  to RW0_addr
- sram_wdata  out  DATA_W  to RW0_wdata
- sram_rdata  in  DATA_W  from RW0_rdata; valid the cycle after a read enable

## Operation
- Definitions:
  - pop = io_r_resp_valid && io_r_resp_ready.
  - credit_ok = (count + s1_valid − pop) < RESP_DEPTH.
  - rd_elig = io_r_req_valid && credit_ok.
- Arbitration, one grant per cycle:
  - If streak == WR_STREAK_MAX and rd_elig: grant read.
  - Else if io_w_req_valid: grant write.
  - Else if rd_elig: grant read.
- Handshake outputs:
  - io_w_req_ready = write granted.
  - io_r_req_ready = read granted.
  - Ready is never asserted for a channel that is not granted.
  - io_r_req_ready combinationally depends on io_r_resp_ready through pop; this path is intended.
- SRAM drive, combinational from the grant:
  - sram_en = any grant.
  - sram_wmode = write granted.
  - sram_addr = address of the granted channel.
  - sram_wdata = io_w_req_data.
  - When no grant: sram_en = 0; addr, wdata and wmode are don't-care.
- Streak counter, sized to hold WR_STREAK_MAX:
  - Increments on a write grant while rd_elig.
  - Clears on a read grant, or in any cycle rd_elig is 0.
  - Saturates at WR_STREAK_MAX.
- Read pipeline:
  - A read grant sets s1_valid at the next edge.
  - While s1_valid, sram_rdata is pushed into the FIFO at the end of that cycle.
  - s1_valid clears unless another read is granted.
- Response FIFO:
  - RESP_DEPTH entries; circular read/write pointers plus a count register.
  - io_r_resp_valid = (count != 0).
  - io_r_resp_data = head entry.
  - Push and pop in the same cycle: count is unchanged and both pointers advance.
  - Push when full cannot occur; credit_ok guarantees this. Verification asserts it.
- Ordering and coherence:
  - Responses return in request-acceptance order.
  - Write at cycle T followed by a read of the same address at T+1 returns the new data; the macro provides this.
  - A write and a read are never issued in the same cycle.

## Timing
- Reset (asynchronous assert):
  - s1_valid = 0, count = 0, pointers = 0, streak = 0.
  - While reset is high: io_r_req_ready = 0, io_w_req_ready = 0, sram_en = 0, io_r_resp_valid = 0.
- Reset mid-operation: in-flight read and all FIFO contents are discarded. Nothing is returned after deassert.
- Read latency:
  - Request accepted at edge T.
  - sram_rdata valid during cycle T+1.
  - io_r_resp_valid high from cycle T+2 if the FIFO was empty.
  - Minimum 2 cycles accept-to-response.
- Throughput: one read per cycle sustained when io_r_resp_ready is held high, because credit counts the same-cycle pop.
- Write: accepted and committed to the macro at the same edge. No response.
- Full stall: with count = RESP_DEPTH and no pop, reads are blocked. Writes still proceed.

## Test plan
- Single read after reset:
  - Stimulus: write addr 5 = 0xA5…A5 at cycle 1, read addr 5 at cycle 2, resp_ready = 1.
  - Required: resp_valid in cycle 4 with data 0xA5…A5; sram_en high in cycles 1 and 2 only.
- Back-to-back reads:
  - Stimulus: preload addrs 0..7 with value = addr; issue 8 consecutive reads with resp_ready = 1.
  - Required: one accept per cycle; responses 0..7 in order on consecutive cycles starting 2 cycles after the first accept.
- Backpressure:
  - Stimulus: resp_ready = 0; offer 4 reads.
  - Required: exactly 2 accepted, r_req_ready = 0 afterwards, count = 2.
  - Then raise resp_ready: data returns in order; the remaining reads resume with no loss or duplication.
- Starvation limit:
  - Stimulus: w_req_valid and r_req_valid held high continuously.
  - Required: grant pattern W,W,W,W,R repeating.
- Read-after-write:
  - Stimulus: write addr 9 = X at T; read addr 9 at T+1.
  - Required: the response is X.
- Async reset mid-flight:
  - Stimulus: assert reset between a read accept and its response, holding 2 entries in the FIFO.
  - Required: outputs go to reset values immediately; after deassert no resp_valid until a new read is accepted.
